// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and lap-time FIFO.
// Turns start/stop and lap/reset pulses into counter strobes and buffers laps.
module stopwatch_ctrl #(
  parameter int LAP_DEPTH = 4,
  localparam int CW = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk_1hz,
  input  logic          rst,
  input  logic          btn_ss,
  input  logic          btn_lr,
  input  logic [5:0]    cur_sec,
  input  logic [5:0]    cur_min,
  input  logic [4:0]    cur_hr,
  input  logic          lap_rd,
  output logic          sw_en,
  output logic          sw_rst,
  output logic [1:0]    state,
  output logic          lap_valid,
  output logic [5:0]    lap_sec,
  output logic [5:0]    lap_min,
  output logic [4:0]    lap_hr,
  output logic [CW-1:0] lap_count,
  output logic          lap_full,
  output logic          lap_ovf
);

  localparam int PW = $clog2(LAP_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [16:0]   r_mem [LAP_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic          w_lr;
  logic          w_push;
  logic          w_flush;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [16:0]   w_head;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(LAP_DEPTH - 1))
      f_inc = '0;
    else
      f_inc = p + PW'(1);
  endfunction

  // start/stop always beats lap/reset
  assign w_lr    = btn_lr & ~btn_ss;
  assign w_push  = (r_state == S_RUN) & w_lr;
  assign w_flush = (r_state == S_PAUSE) & w_lr;
  assign w_full  = (r_cnt == CW'(LAP_DEPTH));
  assign w_pop   = lap_rd & (r_cnt != '0)
                 & ~w_flush & (r_state != S_CLEAR);
  assign w_wr    = w_push & (~w_full | w_pop);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (btn_ss) w_next = S_RUN;
      S_RUN:   if (btn_ss) w_next = S_PAUSE;
      S_PAUSE: begin
        if (btn_ss)    w_next = S_RUN;
        else if (w_lr) w_next = S_CLEAR;
      end
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= f_inc(r_wp);
      if (w_pop) r_rp <= f_inc(r_rp);
      if (w_wr && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_wr)
        r_cnt <= r_cnt - CW'(1);
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (w_wr) r_mem[r_wp] <= {cur_hr, cur_min, cur_sec};
  end

  assign w_head    = (r_cnt != '0) ? r_mem[r_rp] : 17'd0;

  assign state     = r_state;
  assign sw_en     = (r_state == S_RUN);
  assign sw_rst    = (r_state == S_CLEAR);
  assign lap_valid = (r_cnt != '0);
  assign lap_hr    = w_head[16:12];
  assign lap_min   = w_head[11:6];
  assign lap_sec   = w_head[5:0];
  assign lap_count = r_cnt;
  assign lap_full  = w_full;
  assign lap_ovf   = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_stopwatch_ctrl;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [5:0] cur_sec = '0;
  logic [5:0] cur_min = '0;
  logic [4:0] cur_hr = '0;
  logic       lap_rd = 1'b0;
  logic       sw_en;
  logic       sw_rst;
  logic [1:0] state;
  logic       lap_valid;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic [4:0] lap_hr;
  logic [2:0] lap_count;
  logic       lap_full;
  logic       lap_ovf;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.LAP_DEPTH(4)) dut (
    .clk_1hz(clk_1hz), .rst(rst),
    .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cur_sec(cur_sec), .cur_min(cur_min),
    .cur_hr(cur_hr), .lap_rd(lap_rd),
    .sw_en(sw_en), .sw_rst(sw_rst),
    .state(state), .lap_valid(lap_valid),
    .lap_sec(lap_sec), .lap_min(lap_min),
    .lap_hr(lap_hr), .lap_count(lap_count),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic press_ss();
    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
  endtask

  task automatic lap(input int s, input int m, input int h);
    cur_sec = 6'(s); cur_min = 6'(m); cur_hr = 5'(h);
    btn_lr = 1'b1; tick(); btn_lr = 1'b0;
  endtask

  task automatic pop();
    lap_rd = 1'b1; tick(); lap_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({state, sw_en, sw_rst, lap_valid, lap_count,
         lap_full, lap_ovf, lap_sec, lap_min, lap_hr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs state=%0d en=%0d cnt=%0d ovf=%0d",
               state, sw_en, lap_count, lap_ovf);
    end
    rst = 1'b0;
    tick();
    btn_lr = 1'b1; tick(); btn_lr = 1'b0;
    checks++;
    if (state !== 2'd0 || lap_count !== 3'd0) begin
      errors++;
      $display("FAIL idle_lr_ignored state=%0d cnt=%0d exp 0 0",
               state, lap_count);
    end
  endtask

  task automatic test_start_stop();
    press_ss();
    checks++;
    if (state !== 2'd1 || sw_en !== 1'b1) begin
      errors++;
      $display("FAIL start state=%0d en=%0d exp 1 1", state, sw_en);
    end
    repeat (6) tick();
    press_ss();
    checks++;
    if (state !== 2'd2 || sw_en !== 1'b0) begin
      errors++;
      $display("FAIL stop state=%0d en=%0d exp 2 0", state, sw_en);
    end
    press_ss();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL resume state=%0d exp 1", state);
    end
  endtask

  task automatic test_lap();
    lap(7, 0, 0);
    checks++;
    if (lap_valid !== 1'b1 || lap_count !== 3'd1 || lap_sec !== 6'd7
        || lap_min !== 6'd0 || lap_hr !== 5'd0) begin
      errors++;
      $display("FAIL lap_push v=%0d cnt=%0d sec=%0d exp 1 1 7",
               lap_valid, lap_count, lap_sec);
    end
    pop();
    checks++;
    if (lap_valid !== 1'b0 || lap_sec !== 6'd0 || lap_count !== 3'd0) begin
      errors++;
      $display("FAIL lap_pop v=%0d sec=%0d exp 0 0", lap_valid, lap_sec);
    end
    pop();
    checks++;
    if (lap_count !== 3'd0 || lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop cnt=%0d exp 0", lap_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) lap(i, i + 10, i);
    checks++;
    if (lap_full !== 1'b1 || lap_ovf !== 1'b1 || lap_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf full=%0d ovf=%0d cnt=%0d exp 1 1 4",
               lap_full, lap_ovf, lap_count);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (lap_sec !== 6'(i) || lap_min !== 6'(i + 10)
          || lap_hr !== 5'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d got %0d:%0d:%0d exp %0d:%0d:%0d",
                 i, lap_hr, lap_min, lap_sec, i, i + 10, i);
      end
      pop();
    end
    checks++;
    if (lap_valid !== 1'b0 || lap_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained v=%0d ovf=%0d exp 0 1",
               lap_valid, lap_ovf);
    end
  endtask

  task automatic test_clear();
    for (int i = 20; i < 23; i++) lap(i, 0, 0);
    press_ss();
    btn_lr = 1'b1; tick(); btn_lr = 1'b0;
    checks++;
    if (state !== 2'd3 || sw_rst !== 1'b1 || sw_en !== 1'b0
        || lap_count !== 3'd0 || lap_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear st=%0d rst=%0d en=%0d cnt=%0d ovf=%0d exp 3 1 0 0 0",
               state, sw_rst, sw_en, lap_count, lap_ovf);
    end
    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
    checks++;
    if (state !== 2'd0 || sw_rst !== 1'b0 || lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_exit st=%0d rst=%0d exp 0 0", state, sw_rst);
    end
  endtask

  task automatic test_back_to_back();
    press_ss();
    for (int i = 1; i <= 4; i++) lap(i, 0, 0);
    cur_sec = 6'd9;
    btn_lr = 1'b1; lap_rd = 1'b1; tick();
    btn_lr = 1'b0; lap_rd = 1'b0;
    checks++;
    if (lap_count !== 3'd4 || lap_ovf !== 1'b0 || lap_sec !== 6'd2) begin
      errors++;
      $display("FAIL push_pop cnt=%0d ovf=%0d head=%0d exp 4 0 2",
               lap_count, lap_ovf, lap_sec);
    end
    for (int i = 0; i < 4; i++) begin
      logic [5:0] exp_s;
      exp_s = (i == 3) ? 6'd9 : 6'(i + 2);
      checks++;
      if (lap_sec !== exp_s) begin
        errors++;
        $display("FAIL b2b_pop%0d got %0d exp %0d", i, lap_sec, exp_s);
      end
      pop();
    end
  endtask

  task automatic test_priority();
    btn_ss = 1'b1; btn_lr = 1'b1; tick();
    btn_ss = 1'b0; btn_lr = 1'b0;
    checks++;
    if (state !== 2'd2 || lap_count !== 3'd0) begin
      errors++;
      $display("FAIL prio_run st=%0d cnt=%0d exp 2 0", state, lap_count);
    end
    btn_ss = 1'b1; btn_lr = 1'b1; tick();
    btn_ss = 1'b0; btn_lr = 1'b0;
    checks++;
    if (state !== 2'd1 || sw_rst !== 1'b0) begin
      errors++;
      $display("FAIL prio_pause st=%0d rst=%0d exp 1 0", state, sw_rst);
    end
    lap(33, 0, 0);
    press_ss();
    btn_lr = 1'b1; tick(); btn_lr = 1'b0;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL pre_rst_clear st=%0d exp 3", state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || sw_rst !== 1'b0 || sw_en !== 1'b0) begin
      errors++;
      $display("FAIL async_rst st=%0d rst=%0d exp 0 0", state, sw_rst);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_lap();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM and lap buffer for the stopwatch counter. Turns two one-cycle button pulses into the counter's enable and clear strobes (sw_en, sw_rst). Captures lap times into a small FIFO that the display/readout logic drains. Sits between the debounced button logic and the stopwatch counter, in the clk_1hz domain.

Parameters:
LAP_DEPTH, 4, lap FIFO depth in entries; legal range 2..16.
CW, $clog2(LAP_DEPTH+1), width of lap_count (derived, not overridable).

Ports:
clk_1hz  input  1  clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-high.
btn_ss  input  1  start/stop pulse; one cycle, synchronous, already debounced.
btn_lr  input  1  lap/reset pulse; one cycle, synchronous, already debounced.
cur_sec  input  6  live stopwatch seconds, 0..59.
cur_min  input  6  live stopwatch minutes, 0..59.
cur_hr  input  5  live stopwatch hours, 0..23.
lap_rd  input  1  pop request for the lap FIFO head.
sw_en  output  1  count enable to the stopwatch counter.
sw_rst  output  1  synchronous clear to the stopwatch counter.
state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, CLEAR=3.
lap_valid  output  1  FIFO holds at least one entry.
lap_sec  output  6  seconds field of the FIFO head.
lap_min  output  6  minutes field of the FIFO head.
lap_hr  output  5  hours field of the FIFO head.
lap_count  output  CW  number of entries in the FIFO.
lap_full  output  1  lap_count equals LAP_DEPTH.
lap_ovf  output  1  sticky flag: a lap was dropped because the FIFO was full.

Behaviour:
- Reset (async):
  - state=IDLE.
  - FIFO empty: read/write pointers and lap_count = 0.
  - lap_ovf=0.
  - All outputs 0 during and after reset.
- Moore outputs decoded from the registered state:
  - sw_en=1 only in RUN.
  - sw_rst=1 only in CLEAR.
- Transitions, evaluated at each rising edge:
  - IDLE: btn_ss -> RUN. btn_lr ignored.
  - RUN:
    - btn_ss -> PAUSE.
    - btn_lr with no btn_ss -> stay in RUN and push a lap.
  - PAUSE:
    - btn_ss -> RUN.
    - btn_lr with no btn_ss -> CLEAR.
  - CLEAR: unconditionally -> IDLE after exactly one cycle; buttons ignored. Entering CLEAR (same edge as the PAUSE->CLEAR transition):
    - FIFO flushed: lap_count=0, pointers=0.
    - lap_ovf=0.
- Button priority: btn_ss and btn_lr asserted together -> btn_ss wins and btn_lr is dropped (no lap, no clear).
- Lap push:
  - Entry is {cur_hr, cur_min, cur_sec} sampled at the edge where btn_lr is seen in RUN. This is the value the counter shows before its own increment at that edge.
  - Entry width is 17 bits.
  - Stored verbatim; no range check.
- Full FIFO:
  - Push without a same-cycle pop -> entry dropped, lap_ovf set to 1. lap_ovf stays set until CLEAR or rst.
  - Push together with a valid pop -> both happen, lap_count unchanged, no overflow.
- Pop:
  - lap_rd && lap_valid -> head advances at the edge.
  - lap_rd while empty -> ignored, no underflow.
  - Pops are allowed in every state except CLEAR, where the flush wins.
- Head fields:
  - lap_sec/min/hr are combinational from storage at the read pointer.
  - They read as 0 when lap_valid=0.
  - Latency: a lap pushed at edge N is visible (lap_valid=1) after edge N.
- Pointers: wrap modulo LAP_DEPTH. lap_count never exceeds LAP_DEPTH.
- Counter clear path: sw_rst is high for one full cycle, so the counter clears at the edge that leaves CLEAR.
- Reset mid-operation: rst in any state, including CLEAR, immediately forces the reset values above. The FIFO contents are lost.

Test Plan:
1. Reset, then btn_ss at cycle 2 -> state=RUN, sw_en=1 from cycle 3. btn_ss at cycle 10 -> state=PAUSE, sw_en=0.
2. RUN with cur=00:00:07, pulse btn_lr -> lap_valid=1, lap_count=1, lap_sec=7, lap_min=0, lap_hr=0. Then lap_rd for 1 cycle -> lap_valid=0, lap_sec=0.
3. LAP_DEPTH=4: five laps in RUN (sec=1,2,3,4,5) -> lap_full=1, lap_ovf=1. Pops return 1,2,3,4 in order; entry 5 is absent.
4. FIFO full, with btn_lr and lap_rd in the same cycle (sec=9) -> lap_count stays 4, lap_ovf unchanged. Four pops return 2,3,4,9.
5. PAUSE with 3 laps stored, btn_lr -> state=CLEAR for exactly one cycle with sw_rst=1, sw_en=0. Then IDLE, lap_count=0, lap_ovf=0.
6. btn_ss and btn_lr together in RUN -> PAUSE, no lap pushed. Same pair in PAUSE -> RUN, no CLEAR. Then assert rst during CLEAR -> state=IDLE and sw_rst=0 immediately.
